// File: rtl/bist_pkg.sv
// Shared types and helpers for the CUT BIST controller: FSM state encoding,
// signature width, polynomial tap mask and the shift/feedback step used by
// both the pattern LFSR and the response MISR.
package bist_pkg;

  localparam int          SIG_W    = 16;
  localparam logic [15:0] TAP_MASK = 16'hB400;  // taps at bits 15, 13, 12, 10

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CRST  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } bist_state_e;

  // One Fibonacci shift-left step: feedback is the XOR of the tapped bits.
  function automatic logic [SIG_W-1:0] lfsr_step(input logic [SIG_W-1:0] value,
                                                  input logic [SIG_W-1:0] tap_mask);
    return {value[SIG_W-2:0], ^(value & tap_mask)};
  endfunction

endpackage

// File: rtl/cut_bist_controller_if.sv
// Bundle of the run-control handshake and the CUT stimulus/response wires.
// master = host/CUT side, slave = the BIST controller.
interface cut_bist_controller_if #(
  parameter int N_IN = 3
);
  logic                      start;
  logic [N_IN-1:0]           dut_in;
  logic                      dut_rst;
  logic                      dut_out;
  logic                      busy;
  logic                      done;
  logic                      pass;
  logic [bist_pkg::SIG_W-1:0] signature;

  modport master (
    output start, dut_out,
    input  dut_in, dut_rst, busy, done, pass, signature
  );

  modport slave (
    input  start, dut_out,
    output dut_in, dut_rst, busy, done, pass, signature
  );
endinterface

// File: rtl/bist_lfsr16.sv
// 16-bit load/enable shift register with serial-in XOR. Used once as the
// pattern LFSR (si tied low) and once as the response MISR (si = CUT output).
module bist_lfsr16
  import bist_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [SIG_W-1:0] load_val_i,
  input  logic             en_i,
  input  logic             si_i,
  output logic [SIG_W-1:0] q_o
);

  logic [SIG_W-1:0] q_q;
  logic [SIG_W-1:0] q_d;

  // Next value: load wins over step; otherwise hold.
  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = load_val_i;
    end else if (en_i) begin
      q_d = lfsr_step(q_q, TAP_MASK) ^ {{(SIG_W-1){1'b0}}, si_i};
    end else begin
      q_d = q_q;
    end
  end

  // State register with synchronous reset to zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_q <= {SIG_W{1'b0}};
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/cut_bist_controller.sv
// BIST controller: resets the CUT, streams PATTERNS LFSR patterns into it,
// compacts the LAT-delayed response bits into a MISR and compares the final
// signature against GOLDEN.
module cut_bist_controller
  import bist_pkg::*;
#(
  parameter int          N_IN     = 3,
  parameter int          PATTERNS = 1000,
  parameter int          LAT      = 3,
  parameter logic [15:0] SEED     = 16'h0001,
  parameter logic [15:0] GOLDEN   = 16'h0000
) (
  input logic                  I1470_clk,
  input logic                  I1477_rst,
  cut_bist_controller_if.slave bus
);

  localparam int             PW         = $clog2(PATTERNS + 1);
  localparam logic [15:0]    SEED_EFF   = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [PW-1:0]  PAT_LAST   = PW'(PATTERNS - 1);
  localparam logic [PW-1:0]  PAT_MAX    = PW'(PATTERNS);
  localparam logic [3:0]     DRAIN_LAST = 4'(LAT - 1);

  bist_state_e      state_q, state_d;
  logic [PW-1:0]    pat_cnt_q, pat_cnt_d;
  logic [3:0]       drain_cnt_q, drain_cnt_d;
  logic             crst_cnt_q, crst_cnt_d;
  logic [LAT-1:0]   valid_q, valid_d;
  logic             pass_q, pass_d;
  logic             load_s;
  logic             lfsr_en_s;
  logic [SIG_W-1:0] lfsr_q;
  logic [SIG_W-1:0] misr_q;
  logic             lfsr_unused_s;

  // Next-state and control decode for the run sequence.
  always_comb begin
    state_d     = state_q;
    pat_cnt_d   = pat_cnt_q;
    drain_cnt_d = drain_cnt_q;
    crst_cnt_d  = crst_cnt_q;
    pass_d      = pass_q;
    load_s      = 1'b0;
    lfsr_en_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d     = ST_CRST;
          load_s      = 1'b1;
          pass_d      = 1'b0;
          pat_cnt_d   = {PW{1'b0}};
          drain_cnt_d = 4'd0;
          crst_cnt_d  = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CRST: begin
        if (crst_cnt_q) begin
          state_d    = ST_RUN;
          crst_cnt_d = 1'b0;
        end else begin
          crst_cnt_d = 1'b1;
        end
      end
      ST_RUN: begin
        lfsr_en_s = 1'b1;
        // Saturating so the counter can never wrap.
        if (pat_cnt_q != PAT_MAX) begin
          pat_cnt_d = pat_cnt_q + PW'(1);
        end else begin
          pat_cnt_d = pat_cnt_q;
        end
        if (pat_cnt_q == PAT_LAST) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = 4'd0;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q == DRAIN_LAST) begin
          state_d = ST_DONE;
        end else begin
          drain_cnt_d = drain_cnt_q + 4'd1;
        end
      end
      ST_DONE: begin
        // Last capture landed on the edge into DONE, so the MISR is final here.
        pass_d  = (misr_q == GOLDEN);
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Capture-valid pipeline: marks which cycles carry a response to a RUN pattern.
  always_comb begin
    valid_d    = valid_q;
    valid_d[0] = (state_q == ST_RUN);
    for (int i = 1; i < LAT; i++) begin
      valid_d[i] = valid_q[i-1];
    end
  end

  // Control registers; reset aborts any run in progress.
  always_ff @(posedge I1470_clk) begin
    if (I1477_rst) begin
      state_q     <= ST_IDLE;
      pat_cnt_q   <= {PW{1'b0}};
      drain_cnt_q <= 4'd0;
      crst_cnt_q  <= 1'b0;
      valid_q     <= {LAT{1'b0}};
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pat_cnt_q   <= pat_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      crst_cnt_q  <= crst_cnt_d;
      valid_q     <= valid_d;
      pass_q      <= pass_d;
    end
  end

  bist_lfsr16 u_lfsr (
    .clk_i      (I1470_clk),
    .rst_i      (I1477_rst),
    .load_i     (load_s),
    .load_val_i (SEED_EFF),
    .en_i       (lfsr_en_s),
    .si_i       (1'b0),
    .q_o        (lfsr_q)
  );

  bist_lfsr16 u_misr (
    .clk_i      (I1470_clk),
    .rst_i      (I1477_rst),
    .load_i     (load_s),
    .load_val_i ({SIG_W{1'b0}}),
    .en_i       (valid_q[LAT-1]),
    .si_i       (bus.dut_out),
    .q_o        (misr_q)
  );

  // Only the low N_IN LFSR bits reach the CUT.
  assign lfsr_unused_s = ^lfsr_q;

  assign bus.dut_in    = (state_q == ST_RUN) ? lfsr_q[N_IN-1:0] : {N_IN{1'b0}};
  assign bus.dut_rst   = I1477_rst | (state_q == ST_CRST);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.pass      = pass_q;
  assign bus.signature = misr_q;

endmodule

// File: tb/tb_cut_bist_controller.sv
// Directed bench for cut_bist_controller: pattern sequence, run length,
// signature/pass with a constant CUT, dropped starts, mid-run reset, SEED=0
// and a 1000-pattern run against a reference CUT model.
module tb_cut_bist_controller;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total  = 0;
  int   passes = 0;

  always #5 clk = ~clk;

  cut_bist_controller_if #(.N_IN(3)) if0 ();
  cut_bist_controller_if #(.N_IN(3)) if1 ();
  cut_bist_controller_if #(.N_IN(3)) if2 ();
  cut_bist_controller_if #(.N_IN(3)) if3 ();
  cut_bist_controller_if #(.N_IN(3)) if4 ();

  cut_bist_controller #(.N_IN(3), .PATTERNS(4), .LAT(3), .SEED(16'h0001), .GOLDEN(16'h0000))
    u0 (.I1470_clk(clk), .I1477_rst(rst), .bus(if0));
  cut_bist_controller #(.N_IN(3), .PATTERNS(3), .LAT(3), .SEED(16'h0001), .GOLDEN(16'h0007))
    u1 (.I1470_clk(clk), .I1477_rst(rst), .bus(if1));
  cut_bist_controller #(.N_IN(3), .PATTERNS(3), .LAT(3), .SEED(16'h0001), .GOLDEN(16'h0006))
    u2 (.I1470_clk(clk), .I1477_rst(rst), .bus(if2));
  cut_bist_controller #(.N_IN(3), .PATTERNS(4), .LAT(3), .SEED(16'h0000), .GOLDEN(16'h0000))
    u3 (.I1470_clk(clk), .I1477_rst(rst), .bus(if3));
  cut_bist_controller #(.N_IN(3), .PATTERNS(1000), .LAT(3), .SEED(16'hACE1), .GOLDEN(16'h0000))
    u4 (.I1470_clk(clk), .I1477_rst(rst), .bus(if4));

  // Reference CUT for u4: XOR of its inputs, visible 3 cycles after the pattern.
  logic [2:0] cut_pipe;
  always @(posedge clk) begin
    if (rst) cut_pipe <= 3'b000;
    else     cut_pipe <= {cut_pipe[1:0], ^if4.dut_in};
  end
  assign if4.dut_out = cut_pipe[2];

  function automatic logic [15:0] step16(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  logic [2:0]  exp_pat [4];
  logic [15:0] sig_tab [4];
  logic [15:0] model_lf, model_ms;
  int          busy_cnt, done_cnt, done_at;

  initial begin
    exp_pat = '{3'b001, 3'b010, 3'b100, 3'b000};
    sig_tab = '{16'h0000, 16'h0001, 16'h0003, 16'h0007};
    if0.start = 1'b0; if1.start = 1'b0; if2.start = 1'b0; if3.start = 1'b0; if4.start = 1'b0;
    if0.dut_out = 1'b0; if3.dut_out = 1'b0; if1.dut_out = 1'b1; if2.dut_out = 1'b1;

    // Reference signature for the 1000-pattern run.
    model_lf = 16'hACE1;
    model_ms = 16'h0000;
    for (int k = 0; k < 1000; k++) begin
      model_ms = step16(model_ms) ^ {15'd0, ^model_lf[2:0]};
      model_lf = step16(model_lf);
    end

    // Reset state
    @(negedge clk); @(negedge clk);
    check("rst_busy", if0.busy, 32'd0);
    check("rst_done", if0.done, 32'd0);
    check("rst_pass", if0.pass, 32'd0);
    check("rst_sig", if0.signature, 32'd0);
    check("rst_din", if0.dut_in, 32'd0);
    check("rst_dutrst", if0.dut_rst, 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_dutrst", if0.dut_rst, 32'd0);

    // Pattern sequence and run length (u0 SEED=1, u3 SEED=0)
    if0.start = 1'b1; if3.start = 1'b1;
    busy_cnt = 0; done_cnt = 0; done_at = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) begin if0.start = 1'b0; if3.start = 1'b0; end
      if (if0.busy) busy_cnt++;
      if (if0.done) begin done_cnt++; done_at = c; end
      if (c <= 2) check("crst_dutrst", if0.dut_rst, 32'd1);
      if (c == 3) check("run_dutrst", if0.dut_rst, 32'd0);
      if (c >= 3 && c <= 6) begin
        check("u0_pattern", if0.dut_in, 32'(exp_pat[c-3]));
        check("u3_pattern", if3.dut_in, 32'(exp_pat[c-3]));
      end
      if (c >= 7 && c <= 9) check("drain_din", if0.dut_in, 32'd0);
    end
    check("busy_span", busy_cnt, 32'd10);
    check("done_count", done_cnt, 32'd1);
    check("done_cycle", done_at, 32'd10);
    check("u3_idle", if3.busy, 32'd0);
    check("u0_sig_zero", if0.signature, 32'd0);
    check("u0_pass", if0.pass, 32'd1);

    // Signature stepping, pass with GOLDEN 7 and fail with GOLDEN 6
    if1.start = 1'b1; if2.start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) begin if1.start = 1'b0; if2.start = 1'b0; end
      if (c >= 6 && c <= 9) begin
        check("u1_sig", if1.signature, 32'(sig_tab[c-6]));
        check("u2_sig", if2.signature, 32'(sig_tab[c-6]));
      end
      if (c == 9) begin
        check("u1_done", if1.done, 32'd1);
        check("u2_done", if2.done, 32'd1);
      end
      if (c == 10) begin
        check("u1_pass", if1.pass, 32'd1);
        check("u2_pass", if2.pass, 32'd0);
        check("u1_sig_held", if1.signature, 32'h7);
        check("u1_idle", if1.busy, 32'd0);
      end
    end
    repeat (3) @(negedge clk);
    check("u1_pass_held", if1.pass, 32'd1);
    check("u2_pass_held", if2.pass, 32'd0);

    // Starts during RUN and during DONE are dropped
    if1.start = 1'b1;
    done_cnt = 0; done_at = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) begin if1.start = 1'b0; check("pass_cleared", if1.pass, 32'd0); end
      if (c == 4) if1.start = 1'b1;
      if (c == 5) if1.start = 1'b0;
      if (c == 9) if1.start = 1'b1;
      if (c == 10) begin if1.start = 1'b0; check("done_start_dropped", if1.busy, 32'd0); end
      if (if1.done) begin done_cnt++; done_at = c; end
    end
    check("drop_done_count", done_cnt, 32'd1);
    check("drop_done_cycle", done_at, 32'd9);
    check("drop_pass", if1.pass, 32'd1);

    // Reset in DRAIN aborts the run
    if1.start = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      if (c == 1) if1.start = 1'b0;
    end
    check("pre_rst_sig", if1.signature, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", if1.busy, 32'd0);
    check("abort_sig", if1.signature, 32'd0);
    check("abort_dutrst", if1.dut_rst, 32'd1);
    check("abort_u0_pass", if0.pass, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("abort_dutrst_low", if1.dut_rst, 32'd0);
    check("abort_idle", if1.busy, 32'd0);
    if1.start = 1'b1;
    done_at = 0;
    for (int c = 1; c <= 40 && done_at == 0; c++) begin
      @(negedge clk);
      if (c == 1) if1.start = 1'b0;
      if (if1.done) done_at = c;
    end
    check("rerun_done_cycle", done_at, 32'd9);
    check("rerun_sig", if1.signature, 32'h7);
    @(negedge clk);
    check("rerun_pass", if1.pass, 32'd1);

    // 1000-pattern run against the reference CUT
    if4.start = 1'b1;
    done_at = 0;
    for (int c = 1; c <= 1100 && done_at == 0; c++) begin
      @(negedge clk);
      if (c == 1) if4.start = 1'b0;
      if (if4.done) done_at = c;
    end
    check("long_done_cycle", done_at, 32'd1006);
    check("long_sig", if4.signature, 32'(model_ms));
    @(negedge clk);
    check("long_pass", if4.pass, 32'(model_ms == 16'h0000));

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/cut_bist_controller.md
# cut_bist_controller

Built-in self-test controller that drives a benchmark subcircuit (circuit-under-test, CUT) from the stimulus side and compacts its response: an LFSR pattern generator feeds the CUT data inputs, and a MISR compresses the CUT output into a signature. On completion the signature is compared against a golden value, so a trojan-modified netlist shows up as pass=0. It instantiates beside each netlist in the Benchmark_testing1000 set and is the stimulus/response counterpart to those netlists.

## Interface
Parameters:
- N_IN, 3, number of CUT data inputs driven (excludes CUT clock and reset); 1..16
- PATTERNS, 1000, patterns applied per run; ≥1
- LAT, 3, cycles from pattern applied to the corresponding CUT output being valid; 1..15
- SEED, 16'h0001, LFSR load value; 0 is replaced by 16'h0001
- GOLDEN, 16'h0000, expected final signature

Ports (one clock; reset is synchronous and active-high):
- I1470_clk  in  1  clock; the CUT shares it
- I1477_rst  in  1  synchronous active-high reset
- start  in  1  single-cycle run request; ignored unless in IDLE
- dut_in  out  N_IN  CUT stimulus, equal to lfsr[N_IN-1:0] in RUN, otherwise 0
- dut_rst  out  1  active-high reset to the CUT
- dut_out  in  1  CUT response bit
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on entering DONE
- pass  out  1  (signature == GOLDEN); updated in DONE and held until the next start
- signature  out  16  MISR contents; live during a run, held after

## Operation
- FSM states: IDLE → CRST → RUN → DRAIN → DONE → IDLE.
- IDLE: when start=1, load lfsr=SEED, clear misr, clear pass, clear counters, and go to CRST.
- CRST: hold dut_rst=1 for exactly 2 cycles, then go to RUN.
- RUN: apply one pattern per cycle.
  - Each cycle, lfsr advances and pat_cnt increments.
  - After PATTERNS cycles, go to DRAIN.
- DRAIN: hold dut_in=0 for LAT cycles, then go to DONE.
- DONE: last for one cycle; done=1; pass is registered. Then go to IDLE.
- LFSR update: Fibonacci, shift left, lfsr_next = {lfsr[14:0], lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10]}.
- Capture tracking: a LAT-deep valid shift register is fed 1 in each RUN cycle and 0 otherwise.
- MISR update: when the valid tap is 1, misr_next = {misr[14:0], misr[15]^misr[13]^misr[12]^misr[10]} ^ {15'b0, dut_out}. Otherwise misr holds.
- Captures per run: exactly PATTERNS.
- Counters: pat_cnt width is $clog2(PATTERNS+1) and it never wraps. The DRAIN counter is 4 bits.

## Timing
- Reset values: state=IDLE, dut_in=0, dut_rst=1 while I1477_rst is high and 0 afterwards, busy=0, done=0, pass=0, signature=0.
- Reset asserted in any state aborts the run immediately: on the next edge all outputs take their reset values and the valid pipeline clears.
- A start in cycle t sets busy=1 at t+1.
- Total run length from start to the done pulse: 1 + 2 + PATTERNS + LAT cycles.
- A start that arrives while busy=1, including during DONE, is dropped.
- Back-to-back runs: a start in the cycle right after DONE is accepted.
- dut_out is sampled at the clock edge only; it need not be stable at other times.

## Structure
- Shared package bist_pkg holds:
  - the state enum
  - the 16-bit polynomial tap mask 16'hB400 and the constant SIG_W=16
  - function lfsr_step(value, tap_mask), used by both LFSR and MISR
- One sub-module, bist_lfsr16: a load/enable/serial-in register. Instantiate it twice, with si tied 0 for the LFSR and si=dut_out for the MISR.
- Target size: about 180 lines of RTL.

## Test plan
- SEED=1, PATTERNS=4 → dut_in in RUN cycles is 001, 010, 100, 000; busy spans 1+2+4+LAT cycles.
- dut_out tied 1, PATTERNS=3, LAT=3 → signature steps 0x0001, 0x0003, 0x0007; done pulses; pass=1 when GOLDEN=16'h0007.
- Same run with GOLDEN=16'h0006 → pass=0 after done; pass holds until the next start.
- start pulsed again mid-RUN and during DONE → ignored: no restart, exactly one done pulse.
- I1477_rst=1 for one cycle mid-RUN → next cycle state=IDLE, busy=0, signature=0, dut_rst=0 after reset deasserts; a new start gives a clean full run.
- SEED=0 → behaves identically to SEED=1; PATTERNS=1000 with a reference CUT model → signature matches the model value.
